// File: rtl/sisc_mem_arb.sv
// Round-robin arbiter and fixed-latency access sequencer that shares one
// synchronous memory between instruction fetch, data and debug requesters.
module sisc_mem_arb #(
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_done,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] REQ_IF  = 2'd0;
  localparam logic [1:0] REQ_D   = 2'd1;
  localparam logic [1:0] REQ_DBG = 2'd2;
  localparam int         CW      = 3;

  state_t        state_q;
  logic [1:0]    ptr_q;
  logic [1:0]    id_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    done_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic          busy_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] rdata_q;

  logic          gnt_vld_d;
  logic [1:0]    gnt_id_d;
  logic          sel_we_d;
  logic [AW-1:0] sel_addr_d;
  logic [DW-1:0] sel_wdata_d;

  // Search starts one past the last grant, so a lone requester always wins.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] c;
    logic       found;
    rr_pick = 3'b000;
    found   = 1'b0;
    c       = ptr;
    for (int k = 0; k < 3; k++) begin
      c = (c == REQ_DBG) ? REQ_IF : c + 2'd1;
      if (!found && req[c]) begin
        found   = 1'b1;
        rr_pick = {1'b1, c};
      end
    end
  endfunction

  function automatic logic [2:0] done_vec(input logic [1:0] id);
    done_vec = 3'b001 << id;
  endfunction

  always_comb begin
    {gnt_vld_d, gnt_id_d} = rr_pick({dbg_req, d_req, if_req}, ptr_q);
    sel_we_d    = 1'b0;
    sel_addr_d  = if_addr;
    sel_wdata_d = '0;
    case (gnt_id_d)
      REQ_D: begin
        sel_we_d    = d_we;
        sel_addr_d  = d_addr;
        sel_wdata_d = d_wdata;
      end
      REQ_DBG: begin
        sel_we_d    = dbg_we;
        sel_addr_d  = dbg_addr;
        sel_wdata_d = dbg_wdata;
      end
      default: ;
    endcase
  end

  // The mem_* registers double as the latched request; they clear after ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= REQ_DBG;
      id_q        <= REQ_IF;
      cnt_q       <= '0;
      done_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= '0;
      case (state_q)
        S_IDLE: begin
          if (gnt_vld_d) begin
            state_q     <= S_ACCESS;
            busy_q      <= 1'b1;
            ptr_q       <= gnt_id_d;
            id_q        <= gnt_id_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= sel_we_d;
            mem_addr_q  <= sel_addr_d;
            mem_wdata_q <= sel_wdata_d;
          end
        end
        S_ACCESS: begin
          if (mem_we_q) begin
            state_q <= S_DONE;
            done_q  <= done_vec(id_q);
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= CW'(RD_LAT);
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            rdata_q <= mem_rdata;
            state_q <= S_DONE;
            done_q  <= done_vec(id_q);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_done   = done_q[0];
  assign d_done    = done_q[1];
  assign dbg_done  = done_q[2];
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Bench for sisc_mem_arb: directed scenarios plus a randomized run against a
// transaction-level model, on instances with read latency 1 and 3.
module tb_sisc_mem_arb;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req, d_req, d_we, dbg_req, dbg_we;
  logic [AW-1:0] if_addr, d_addr, dbg_addr;
  logic [DW-1:0] d_wdata, dbg_wdata;

  logic          if_done1, d_done1, dbg_done1, mem_en1, mem_we1, busy1;
  logic [AW-1:0] mem_addr1;
  logic [DW-1:0] mem_wdata1, rdata1, mem_rdata1;
  logic          if_done3, d_done3, dbg_done3, mem_en3, mem_we3, busy3;
  logic [AW-1:0] mem_addr3;
  logic [DW-1:0] mem_wdata3, rdata3, mem_rdata3;

  sisc_mem_arb #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done1),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_done(dbg_done1), .rdata(rdata1), .mem_en(mem_en1), .mem_we(mem_we1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  sisc_mem_arb #(.AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done3),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_done(dbg_done3), .rdata(rdata3), .mem_en(mem_en3), .mem_we(mem_we3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Memory models: reads return garbage except exactly RD_LAT cycles after mem_en.
  logic          pl_en = 1'b0;
  logic [1:0]    pl_m  = 2'b00;
  logic [AW-1:0] pl_a  = '0;
  logic [DW-1:0] pl_d  = '0;
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem3 [256];
  logic [DW-1:0] rpipe1;
  logic [DW-1:0] rpipe3 [3];

  always @(posedge clk) begin
    if (pl_en && pl_m[0]) mem1[pl_a] <= pl_d;
    else if (mem_en1 && mem_we1) mem1[mem_addr1] <= mem_wdata1;
    rpipe1 <= (mem_en1 && !mem_we1) ? mem1[mem_addr1] : $urandom;
  end

  always @(posedge clk) begin
    if (pl_en && pl_m[1]) mem3[pl_a] <= pl_d;
    else if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_wdata3;
    rpipe3[0] <= (mem_en3 && !mem_we3) ? mem3[mem_addr3] : $urandom;
    rpipe3[1] <= rpipe3[0];
    rpipe3[2] <= rpipe3[1];
  end

  assign mem_rdata1 = rpipe1;
  assign mem_rdata3 = rpipe3[2];

  logic          sel3 = 1'b0;
  logic          c_busy, c_mem_en, c_mem_we, c_if_done, c_d_done, c_dbg_done;
  logic [AW-1:0] c_mem_addr;
  logic [DW-1:0] c_mem_wdata, c_rdata;
  assign c_busy      = sel3 ? busy3      : busy1;
  assign c_mem_en    = sel3 ? mem_en3    : mem_en1;
  assign c_mem_we    = sel3 ? mem_we3    : mem_we1;
  assign c_if_done   = sel3 ? if_done3   : if_done1;
  assign c_d_done    = sel3 ? d_done3    : d_done1;
  assign c_dbg_done  = sel3 ? dbg_done3  : dbg_done1;
  assign c_mem_addr  = sel3 ? mem_addr3  : mem_addr1;
  assign c_mem_wdata = sel3 ? mem_wdata3 : mem_wdata1;
  assign c_rdata     = sel3 ? rdata3     : rdata1;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] shadow [256];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_req();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic rst_begin();
    @(negedge clk);
    rst = 1'b1;
    clr_req();
    @(negedge clk);
  endtask

  task automatic rst_end();
    rst = 1'b0;
  endtask

  task automatic mem_load(input logic [1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_m = m; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_begin();
    n_tests++;
    if ({busy1, mem_en1, mem_we1, if_done1, d_done1, dbg_done1} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl1 got=%b exp=000000", {busy1, mem_en1, mem_we1, if_done1, d_done1, dbg_done1});
    end
    n_tests++;
    if (mem_addr1 !== '0 || mem_wdata1 !== '0 || rdata1 !== '0) begin
      n_fail++;
      $display("FAIL reset_data1 got addr=%h wdata=%h rdata=%h exp all 0", mem_addr1, mem_wdata1, rdata1);
    end
    n_tests++;
    if ({busy3, mem_en3, mem_we3, if_done3, d_done3, dbg_done3} !== 6'b0 ||
        mem_addr3 !== '0 || mem_wdata3 !== '0 || rdata3 !== '0) begin
      n_fail++;
      $display("FAIL reset_all3 got busy=%b en=%b rdata=%h exp 0", busy3, mem_en3, rdata3);
    end
    rst_end();
    tick();
    n_tests++;
    if ({busy1, mem_en1} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_no_req got busy/en=%b exp=00", {busy1, mem_en1});
    end
  endtask

  task automatic test_single_fetch();
    rst_begin();
    mem_load(2'b01, 8'h05, 32'h12345678);
    rst_end();
    if_req = 1'b1; if_addr = 8'h05;
    tick();
    n_tests++;
    if ({mem_en1, mem_we1, busy1, if_done1} !== 4'b1010 || mem_addr1 !== 8'h05) begin
      n_fail++;
      $display("FAIL fetch_access got en/we/busy/done=%b addr=%h exp 1010 05", {mem_en1, mem_we1, busy1, if_done1}, mem_addr1);
    end
    if_req = 1'b0; if_addr = 8'hAA;
    tick();
    n_tests++;
    if ({mem_en1, busy1, if_done1} !== 3'b010 || rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL fetch_wait got en/busy/done=%b rdata=%h exp 010 0", {mem_en1, busy1, if_done1}, rdata1);
    end
    tick();
    n_tests++;
    if ({if_done1, d_done1, dbg_done1} !== 3'b100 || rdata1 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL fetch_done got dones=%b rdata=%h exp 100 12345678", {if_done1, d_done1, dbg_done1}, rdata1);
    end
    tick();
    n_tests++;
    if ({busy1, if_done1} !== 2'b00) begin
      n_fail++;
      $display("FAIL fetch_after got busy/done=%b exp=00", {busy1, if_done1});
    end
  endtask

  task automatic test_store_load();
    rst_begin();
    rst_end();
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 32'hDEADBEEF;
    tick();
    n_tests++;
    if ({mem_en1, mem_we1, d_done1} !== 3'b110 || mem_addr1 !== 8'h20 || mem_wdata1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL store_access got en/we/done=%b addr=%h wdata=%h exp 110 20 deadbeef",
               {mem_en1, mem_we1, d_done1}, mem_addr1, mem_wdata1);
    end
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    tick();
    n_tests++;
    if ({d_done1, mem_en1, mem_we1} !== 3'b100 || mem_addr1 !== '0 || mem_wdata1 !== '0) begin
      n_fail++;
      $display("FAIL store_done got done/en/we=%b addr=%h wdata=%h exp 100 0 0", {d_done1, mem_en1, mem_we1}, mem_addr1, mem_wdata1);
    end
    tick();
    n_tests++;
    if ({busy1, d_done1} !== 2'b00) begin
      n_fail++;
      $display("FAIL store_idle got busy/done=%b exp=00", {busy1, d_done1});
    end
    d_req = 1'b1; d_addr = 8'h20;
    tick();
    d_req = 1'b0;
    tick();
    tick();
    n_tests++;
    if (d_done1 !== 1'b1 || rdata1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load_back got done=%b rdata=%h exp 1 deadbeef", d_done1, rdata1);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] vals [3];
    logic [2:0]    dv;
    int            got;
    int            cyc;
    vals[0] = 32'hA0A0_0001; vals[1] = 32'hB1B1_0002; vals[2] = 32'hC2C2_0003;
    rst_begin();
    mem_load(2'b01, 8'h41, vals[0]);
    mem_load(2'b01, 8'h42, vals[1]);
    mem_load(2'b01, 8'h43, vals[2]);
    rst_end();
    if_req = 1'b1; if_addr = 8'h41;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h42;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h43;
    got = 0;
    cyc = 0;
    while (got < 6 && cyc < 100) begin
      tick();
      cyc++;
      dv = {dbg_done1, d_done1, if_done1};
      if (dv !== 3'b000) begin
        n_tests++;
        if (dv !== (3'b001 << (got % 3)) || rdata1 !== vals[got % 3]) begin
          n_fail++;
          $display("FAIL rr_order txn=%0d got dones=%b rdata=%h exp dones=%b rdata=%h",
                   got, dv, rdata1, 3'b001 << (got % 3), vals[got % 3]);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 6) begin
      n_fail++;
      $display("FAIL rr_timeout got %0d completions exp 6", got);
    end
    clr_req();
  endtask

  task automatic test_rdlat3();
    rst_begin();
    mem_load(2'b10, 8'h10, 32'hCAFEF00D);
    rst_end();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h10;
    tick();
    n_tests++;
    if (mem_en3 !== 1'b1 || mem_addr3 !== 8'h10) begin
      n_fail++;
      $display("FAIL lat3_access got en=%b addr=%h exp 1 10", mem_en3, mem_addr3);
    end
    dbg_req = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      n_tests++;
      if ({mem_en3, dbg_done3, busy3} !== 3'b001 || rdata3 !== 32'h0) begin
        n_fail++;
        $display("FAIL lat3_wait cyc=%0d got en/done/busy=%b rdata=%h exp 001 0", c, {mem_en3, dbg_done3, busy3}, rdata3);
      end
    end
    tick();
    n_tests++;
    if (dbg_done3 !== 1'b1 || rdata3 !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL lat3_done got done=%b rdata=%h exp 1 cafef00d", dbg_done3, rdata3);
    end
    tick();
    n_tests++;
    if ({busy3, dbg_done3} !== 2'b00) begin
      n_fail++;
      $display("FAIL lat3_after got busy/done=%b exp=00", {busy3, dbg_done3});
    end
  endtask

  task automatic test_latched();
    int pulses;
    rst_begin();
    rst_end();
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 32'h1111_2222;
    @(posedge clk);
    #1;
    d_addr = 8'h31; d_wdata = 32'h3333_4444; d_we = 1'b0; d_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_en1, mem_we1} !== 2'b11 || mem_addr1 !== 8'h30 || mem_wdata1 !== 32'h1111_2222) begin
      n_fail++;
      $display("FAIL latch_bus got en/we=%b addr=%h wdata=%h exp 11 30 11112222",
               {mem_en1, mem_we1}, mem_addr1, mem_wdata1);
    end
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (d_done1 === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 1 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL latch_done got pulses=%0d busy=%b exp 1 0", pulses, busy1);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int cyc;
    logic [2:0] dv;
    rst_begin();
    mem_load(2'b01, 8'h07, 32'h0BADF00D);
    mem_load(2'b01, 8'h08, 32'h55AA55AA);
    rst_end();
    if_req = 1'b1; if_addr = 8'h07;
    tick(); tick(); tick();
    n_tests++;
    if (if_done1 !== 1'b1 || rdata1 !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL mid_first got done=%b rdata=%h exp 1 0badf00d", if_done1, rdata1);
    end
    if_addr = 8'h08;
    tick();
    tick();
    if_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if ({busy1, mem_en1, if_done1} !== 3'b000 || rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset got busy/en/done=%b rdata=%h exp 000 0", {busy1, mem_en1, if_done1}, rdata1);
    end
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (if_done1 === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL mid_nodone got pulses=%0d exp 0", pulses);
    end
    if_req = 1'b1; if_addr = 8'h07;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h08;
    dv = 3'b000;
    cyc = 0;
    while (dv === 3'b000 && cyc < 20) begin
      tick();
      cyc++;
      dv = {dbg_done1, d_done1, if_done1};
    end
    n_tests++;
    if (dv !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_ptr got first dones=%b exp 001", dv);
    end
    clr_req();
  endtask

  task automatic test_random(input bit use3, input int ncyc);
    int            lat;
    int            m_busy, m_k, m_len, m_own, m_ptr, gi;
    bit            g;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, exp_rd, dword;
    bit            act [3];
    logic [AW-1:0] ra [3];
    logic          rw [3];
    logic [DW-1:0] rd [3];
    logic          e_en, e_we, e_busy;
    logic [2:0]    e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    lat = use3 ? 3 : 1;
    rst_begin();
    sel3 = use3;
    for (int a = 0; a < 256; a++) begin
      dword = $urandom;
      shadow[a] = dword;
      mem_load(use3 ? 2'b10 : 2'b01, AW'(a), dword);
    end
    rst_end();
    m_busy = 0; m_k = 0; m_len = 0; m_own = 0; m_ptr = 2;
    m_we = 1'b0; m_addr = '0; m_wd = '0; exp_rd = '0;
    for (int r = 0; r < 3; r++) begin
      act[r] = 1'b0; ra[r] = '0; rw[r] = 1'b0; rd[r] = '0;
    end
    for (int n = 0; n < ncyc; n++) begin
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_done = 3'b000;
      e_busy = (m_busy != 0);
      if (m_busy != 0) begin
        if (m_k == 1) begin
          e_en = 1'b1; e_we = m_we; e_addr = m_addr; e_wd = m_wd;
          if (m_we) shadow[m_addr] = m_wd;
        end
        if (m_k == m_len) begin
          e_done = 3'b001 << m_own;
          if (!m_we) exp_rd = shadow[m_addr];
        end
      end
      n_tests++;
      if ({c_busy, c_mem_en, c_mem_we} !== {e_busy, e_en, e_we}) begin
        n_fail++;
        $display("FAIL rnd_ctrl lat=%0d cyc=%0d got busy/en/we=%b exp=%b", lat, n, {c_busy, c_mem_en, c_mem_we}, {e_busy, e_en, e_we});
      end
      n_tests++;
      if ({c_dbg_done, c_d_done, c_if_done} !== e_done) begin
        n_fail++;
        $display("FAIL rnd_done lat=%0d cyc=%0d got dones=%b exp=%b", lat, n, {c_dbg_done, c_d_done, c_if_done}, e_done);
      end
      n_tests++;
      if (c_mem_addr !== e_addr || c_mem_wdata !== e_wd) begin
        n_fail++;
        $display("FAIL rnd_bus lat=%0d cyc=%0d got addr=%h wdata=%h exp addr=%h wdata=%h", lat, n, c_mem_addr, c_mem_wdata, e_addr, e_wd);
      end
      n_tests++;
      if (c_rdata !== exp_rd) begin
        n_fail++;
        $display("FAIL rnd_rdata lat=%0d cyc=%0d got=%h exp=%h", lat, n, c_rdata, exp_rd);
      end
      for (int r = 0; r < 3; r++) begin
        if (e_done[r]) begin
          act[r] = ($urandom_range(1, 0) == 1);
          ra[r] = AW'($urandom_range(15, 0)); rw[r] = (r != 0) && ($urandom_range(1, 0) == 1); rd[r] = $urandom;
        end else if (m_busy != 0 && m_own == r) begin
          if ($urandom_range(3, 0) == 0) begin
            ra[r] = AW'($urandom_range(15, 0)); rw[r] = (r != 0) && ($urandom_range(1, 0) == 1); rd[r] = $urandom;
          end
          if ($urandom_range(7, 0) == 0) act[r] = 1'b0;
        end else if (!act[r] && $urandom_range(2, 0) == 0) begin
          act[r] = 1'b1;
          ra[r] = AW'($urandom_range(15, 0)); rw[r] = (r != 0) && ($urandom_range(1, 0) == 1); rd[r] = $urandom;
        end
      end
      if_req = act[0]; if_addr = ra[0];
      d_req = act[1]; d_we = rw[1]; d_addr = ra[1]; d_wdata = rd[1];
      dbg_req = act[2]; dbg_we = rw[2]; dbg_addr = ra[2]; dbg_wdata = rd[2];
      if (m_busy != 0) begin
        if (m_k == m_len) m_busy = 0;
        else m_k++;
      end else begin
        g = 1'b0;
        gi = 0;
        for (int i = 1; i <= 3; i++) begin
          if (!g && act[(m_ptr + i) % 3]) begin
            g = 1'b1;
            gi = (m_ptr + i) % 3;
          end
        end
        if (g) begin
          m_own = gi; m_ptr = gi;
          m_addr = ra[gi];
          m_we = (gi == 0) ? 1'b0 : rw[gi];
          m_wd = (gi == 0) ? '0 : rd[gi];
          m_len = m_we ? 2 : lat + 2;
          m_k = 1;
          m_busy = 1;
        end
      end
      tick();
    end
    clr_req();
    sel3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_req();
    test_reset();
    test_single_fetch();
    test_store_load();
    test_round_robin();
    test_rdlat3();
    test_latched();
    test_reset_mid();
    test_random(1'b0, 400);
    test_random(1'b1, 400);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sisc_mem_arb.md
# sisc_mem_arb

Single-port memory arbiter and access sequencer for the SISC computer. It shares one synchronous memory between three requesters: instruction fetch, data load/store, and the debug/loader port. Requests are granted round-robin, and the block drives the memory port through a fixed-latency access sequence. It sits between `ctrl`/datapath and the unified instruction/data memory, so a stalled fetch or data access no longer depends on fixed FSM cycle slots.

## Interface
Parameters
- `AW`, 8: memory address width (word addressed).
- `DW`, 32: data width.
- `RD_LAT`, 1: memory read latency in cycles, legal range 1..4.

Ports
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `if_req`  in  1: fetch request, level-held until `if_done`.
- `if_addr`  in  AW: fetch address; fetch is always a read.
- `if_done`  out  1: one-cycle completion pulse for fetch.
- `d_req`  in  1: data request, level-held until `d_done`.
- `d_we`  in  1: 1 = store, 0 = load.
- `d_addr`  in  AW: data address.
- `d_wdata`  in  DW: store data.
- `d_done`  out  1: one-cycle completion pulse for data.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_done`: debug port, same widths and meaning as the `d_*` ports.
- `rdata`  out  DW: read data. Valid with any `*_done` of a read, and held until the next read completes.
- `mem_en`  out  1: memory access strobe.
- `mem_we`  out  1: memory write enable, qualified by `mem_en`.
- `mem_addr`  out  AW: memory address.
- `mem_wdata`  out  DW: memory write data.
- `mem_rdata`  in  DW: memory read data, valid `RD_LAT` cycles after the `mem_en` cycle.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE
  - Samples the three `*_req` inputs.
  - If none are asserted, stays in IDLE.
  - Otherwise grants one requester and goes to ACCESS.
  - On grant, latches the requester id, the address, `we` (forced 0 for fetch) and `wdata` into internal registers.
- ACCESS (1 cycle)
  - `mem_en` = 1; `mem_we`, `mem_addr` and `mem_wdata` come from the latched registers.
  - Write: go to DONE.
  - Read: load the WAIT counter with `RD_LAT`, then go to WAIT.
- WAIT (`RD_LAT` cycles)
  - `mem_en` = 0; the counter decrements each cycle.
  - In the last WAIT cycle (counter = 1), `rdata` <= `mem_rdata`; then go to DONE.
- DONE (1 cycle)
  - The granted requester's `*_done` = 1; the other two `*_done` stay 0.
  - Then go to IDLE.
- Arbitration: round-robin over the order fetch -> data -> dbg.
  - A 2-bit pointer holds the last granted requester.
  - The search starts at the requester after the pointer; the first asserted `req` wins.
  - The pointer updates on grant.
  - A lone requester is always granted, regardless of the pointer.
- Latched request: inputs are captured at grant. Changes to `addr`/`wdata`/`we`, or a dropped `req`, after grant do not affect the transaction, and `done` still pulses.
- Re-request: a requester that still asserts `req` in the IDLE cycle after its `done` is treated as a new request.
- Outputs of all `*_done`, `mem_en` and `busy` are Moore outputs of the state register (no combinational path from `*_req`).
- `mem_addr`, `mem_wdata` and `mem_we` are 0 outside ACCESS.

## Timing
- Reset
  - state = IDLE; pointer = dbg, so fetch wins first.
  - All `*_done`, `mem_en`, `mem_we` and `busy` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0, `rdata` = 0, WAIT counter = 0.
- Reset asserted mid-transaction
  - The next cycle is IDLE with all outputs at reset values and no `done` pulse.
  - A write whose ACCESS cycle already occurred is not undone.
- Latency from the IDLE cycle where `req` is sampled to the `done` cycle:
  - write: 2 cycles (ACCESS, DONE);
  - read: `RD_LAT` + 2 cycles.
- Throughput: one transaction per `RD_LAT` + 3 cycles for reads, and per 3 cycles for writes, since DONE always returns to IDLE.
- Simultaneous requests: exactly one grant per IDLE cycle. A losing requester waits at most two further transactions.
- Requests arriving in a non-IDLE state are not lost; they are evaluated in the next IDLE cycle.

## Test plan
- Reset then single fetch: `if_req`=1, `if_addr`=0x05, memory[5]=0x12345678, `RD_LAT`=1 -> `mem_en` high 1 cycle after sampling, `if_done` pulses 3 cycles after sampling, `rdata`=0x12345678, `busy` low in the following cycle.
- Data store then load: `d_we`=1, `d_addr`=0x20, `d_wdata`=0xDEADBEEF -> `mem_we`=1 during ACCESS and `d_done` 2 cycles after sampling. Then a load of 0x20 -> `rdata`=0xDEADBEEF with `d_done`.
- All three requesters held high for 6 transactions -> grant order fetch, data, dbg, fetch, data, dbg; no requester is granted twice before the others are served.
- `RD_LAT`=3: a read of 0x10 -> exactly 3 WAIT cycles, `done` 5 cycles after sampling, and `rdata` unchanged until the DONE cycle.
- After grant, change `d_addr` from 0x30 to 0x31 and drop `d_req` -> `mem_addr`=0x30 and `d_done` still pulses once.
- Assert `rst` during WAIT of a fetch -> next cycle IDLE, `if_done` never pulses, `rdata`=0, pointer = dbg (a subsequent simultaneous fetch/data pair grants fetch).
